pkt_addr_mgmt: RTL

//  Packet buffer address manager feeding data_ctrl. Owns the 2048x134 packet RAM as SLOT_NUM fixed slots.

---
 rtl/pkt_buf_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/pkt_addr_mgmt.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pkt_buf_pkg.sv
// Shared constants and types for the packet buffer address manager.
package pkt_buf_pkg;

  localparam int unsigned SLOT_NUM  = 64;
  localparam int unsigned SLOT_AW   = 6;
  localparam int unsigned SLOT_WLOG = 5;
  localparam int unsigned ADDR_W    = SLOT_AW + SLOT_WLOG;
  localparam int unsigned DATA_W    = 134;

  // Word position tags carried in the top two data bits
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_PKT
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_BUSY,
    R_GAP
  } rd_state_e;

  // RAM word address of the first word of a slot
  function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_AW-1:0] id);
    return {id, {SLOT_WLOG{1'b0}}};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and registered count/empty/full.
module sync_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt_c;
  logic             do_push_c;
  logic             do_pop_c;

  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign rdata     = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    count_nxt_c = count;
    if (do_push_c && !do_pop_c) begin
      count_nxt_c = count + CW'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
      empty <= (count_nxt_c == '0);
      full  <= (count_nxt_c == CW'(DEPTH));
    end
  end

  // Overflow and underflow never happen in correct use
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop)) else $error("sync_fifo: push into full fifo");
      assert (!(pop && empty)) else $error("sync_fifo: pop from empty fifo");
    end
  end

endmodule

// File: rtl/pkt_addr_mgmt.sv
// Packet buffer address manager: slot allocation, read ordering and slot recycling.
module pkt_addr_mgmt
  import pkt_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_pkt_sop,
  input  logic [DATA_W-1:0]   in_pkt_data,
  input  logic                in_pkt_data_wr,
  output logic [ADDR_W-1:0]   addr2data_waddr,
  output logic                addr2data_waddr_wr,
  output logic [ADDR_W-1:0]   addr2data_raddr,
  output logic                addr2data_raddr_wr,
  input  logic                in_cache_valid_wr,
  input  logic                in_out_rdy,
  output logic                out_pkt_drop,
  output logic [SLOT_AW:0]    out_free_cnt,
  output logic                out_init_done
);

  localparam int unsigned CNT_W  = SLOT_AW + 1;
  localparam int unsigned WCNT_W = SLOT_WLOG + 1;
  localparam logic [CNT_W-1:0]  SLOT_NUM_C   = CNT_W'(SLOT_NUM);
  localparam logic [WCNT_W-1:0] SLOT_WORDS_C = WCNT_W'(1 << SLOT_WLOG);

  logic [CNT_W-1:0]   init_cnt;
  logic               init_push_c;

  logic               free_push_c;
  logic [SLOT_AW-1:0] free_wdata_c;
  logic [SLOT_AW-1:0] free_rdata;
  logic               unused_free_empty;
  logic               unused_free_full;

  logic               ready_push_c;
  logic               ready_pop_c;
  logic [SLOT_AW-1:0] ready_rdata;
  logic               ready_empty;
  logic [SLOT_AW:0]   unused_ready_cnt;
  logic               unused_ready_full;

  wr_state_e          wr_state;
  wr_state_e          wr_state_nxt;
  logic [SLOT_AW-1:0] wr_id;
  logic [WCNT_W-1:0]  wcnt;
  logic [WCNT_W-1:0]  wcnt_nxt;
  logic               alloc_c;
  logic               drop_c;

  rd_state_e          rd_state;
  rd_state_e          rd_state_nxt;
  logic [SLOT_AW-1:0] rd_id;
  logic               release_c;

  logic [1:0]         tag_c;
  logic               unused_data;

  assign tag_c       = in_pkt_data[DATA_W-1 -: 2];
  assign unused_data = ^in_pkt_data[DATA_W-3:0];

  // Free list initialisation: push ids 0..SLOT_NUM-1, then flag completion
  assign init_push_c = (init_cnt != SLOT_NUM_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt      <= '0;
      out_init_done <= 1'b0;
    end else begin
      if (init_push_c) init_cnt <= init_cnt + CNT_W'(1);
      out_init_done <= !init_push_c;
    end
  end

  // Free list is fed by init first, then by read-done recycling
  assign free_push_c  = init_push_c || release_c;
  assign free_wdata_c = init_push_c ? init_cnt[SLOT_AW-1:0] : rd_id;

  sync_fifo #(.WIDTH(SLOT_AW), .DEPTH(SLOT_NUM)) free_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (free_push_c),
    .wdata (free_wdata_c),
    .pop   (alloc_c),
    .rdata (free_rdata),
    .count (out_free_cnt),
    .empty (unused_free_empty),
    .full  (unused_free_full)
  );

  sync_fifo #(.WIDTH(SLOT_AW), .DEPTH(SLOT_NUM)) ready_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ready_push_c),
    .wdata (wr_id),
    .pop   (ready_pop_c),
    .rdata (ready_rdata),
    .count (unused_ready_cnt),
    .empty (ready_empty),
    .full  (unused_ready_full)
  );

  // Write FSM next state: allocate on sop, queue the slot on tail
  always_comb begin
    wr_state_nxt = wr_state;
    wcnt_nxt     = wcnt;
    alloc_c      = 1'b0;
    drop_c       = 1'b0;
    ready_push_c = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (in_pkt_sop) begin
          if (out_init_done && (out_free_cnt != '0)) begin
            alloc_c      = 1'b1;
            wcnt_nxt     = '0;
            wr_state_nxt = W_PKT;
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      W_PKT: begin
        if (in_pkt_data_wr) begin
          if (wcnt != SLOT_WORDS_C) wcnt_nxt = wcnt + WCNT_W'(1);
          if (tag_c == TAIL) begin
            ready_push_c = 1'b1;
            wcnt_nxt     = '0;
            wr_state_nxt = W_IDLE;
          end
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM state and write-side output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state           <= W_IDLE;
      wcnt               <= '0;
      wr_id              <= '0;
      addr2data_waddr    <= '0;
      addr2data_waddr_wr <= 1'b0;
      out_pkt_drop       <= 1'b0;
    end else begin
      wr_state           <= wr_state_nxt;
      wcnt               <= wcnt_nxt;
      addr2data_waddr_wr <= alloc_c;
      out_pkt_drop       <= drop_c;
      if (alloc_c) begin
        wr_id           <= free_rdata;
        addr2data_waddr <= slot_base(free_rdata);
      end
    end
  end

  // Read FSM next state: issue oldest ready packet, recycle on read-done, then one idle cycle
  always_comb begin
    rd_state_nxt = rd_state;
    ready_pop_c  = 1'b0;
    release_c    = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (!ready_empty && in_out_rdy) begin
          ready_pop_c  = 1'b1;
          rd_state_nxt = R_BUSY;
        end
      end
      R_BUSY: begin
        if (in_cache_valid_wr) begin
          release_c    = 1'b1;
          rd_state_nxt = R_GAP;
        end
      end
      R_GAP:   rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM state and read-side output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state           <= R_IDLE;
      rd_id              <= '0;
      addr2data_raddr    <= '0;
      addr2data_raddr_wr <= 1'b0;
    end else begin
      rd_state           <= rd_state_nxt;
      addr2data_raddr_wr <= ready_pop_c;
      if (ready_pop_c) begin
        rd_id           <= ready_rdata;
        addr2data_raddr <= slot_base(ready_rdata);
      end
    end
  end

  // Packet protocol sanity: valid word tags and no slot overrun
  always_ff @(posedge clk) begin
    if (rst_n && (wr_state == W_PKT) && in_pkt_data_wr) begin
      assert (wcnt != SLOT_WORDS_C) else $error("pkt_addr_mgmt: packet longer than a slot");
      assert ((tag_c == HEAD) || (tag_c == MID) || (tag_c == TAIL))
        else $error("pkt_addr_mgmt: invalid word tag");
    end
  end

endmodule
